// File: rtl/i2c_reg_reader.sv
// Register-read sequencer for i2c_master: address+W, register pointer, repeated
// START, address+R, then N read bytes returned as a valid/last stream.
module i2c_reg_reader #(
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_dev_addr,
    input  logic [7:0]       req_reg_addr,
    input  logic [LEN_W-1:0] req_len,

    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_last,

    output logic             done,
    output logic             err_nack,
    output logic             err_bus,

    output logic             i2c_mode,
    output logic             i2c_transfer_start,
    output logic             i2c_transfer_continue,
    output logic [7:0]       i2c_data_tx,
    input  logic             i2c_transfer_ready,
    input  logic             i2c_interrupt,
    input  logic             i2c_transaction_complete,
    input  logic             i2c_nack,
    input  logic             i2c_start_err,
    input  logic             i2c_arbitration_err,
    input  logic [7:0]       i2c_data_rx
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ADDR_W,
        REG,
        ADDR_R,
        READ
    } state_t;

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             start_q, start_d;
    logic             cont_q, cont_d;
    logic [7:0]       tx_q, tx_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_last_q, rd_last_d;
    logic             done_q, done_d;
    logic             err_nack_q, err_nack_d;
    logic             err_bus_q, err_bus_d;

    logic             bus_err;
    logic             nack_evt;
    logic             ok;
    logic             fin;
    logic             fin_nack;
    logic             fin_bus;
    logic [LEN_W-1:0] len_clamped;

    assign bus_err     = i2c_interrupt && (i2c_start_err || i2c_arbitration_err);
    assign nack_evt    = i2c_interrupt && i2c_nack && !bus_err;
    assign ok          = i2c_interrupt && i2c_transaction_complete && !bus_err;
    assign len_clamped = (req_len > MAX_CNT) ? MAX_CNT : req_len;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dev_q      <= '0;
            reg_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            start_q    <= 1'b0;
            cont_q     <= 1'b0;
            tx_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
            err_bus_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            cont_q     <= cont_d;
            tx_q       <= tx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_nack_q <= err_nack_d;
            err_bus_q  <= err_bus_d;
        end
    end

    // Master controls hold their value until a qualifying interrupt; strobes default low.
    always_comb begin
        state_d    = state_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        start_d    = start_q;
        cont_d     = cont_q;
        tx_d       = tx_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_last_d  = 1'b0;
        done_d     = 1'b0;
        err_nack_d = 1'b0;
        err_bus_d  = 1'b0;
        fin        = 1'b0;
        fin_nack   = 1'b0;
        fin_bus    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    dev_d   = req_dev_addr;
                    reg_d   = req_reg_addr;
                    cnt_d   = len_clamped;
                    state_d = WAIT_RDY;
                end
            end

            WAIT_RDY: begin
                if (bus_err) begin
                    fin     = 1'b1;
                    fin_bus = 1'b1;
                end else if (i2c_transfer_ready) begin
                    start_d = 1'b1;
                    cont_d  = 1'b1;
                    mode_d  = 1'b0;
                    tx_d    = {dev_q, 1'b0};
                    state_d = ADDR_W;
                end
            end

            ADDR_W: begin
                if (bus_err) begin
                    fin     = 1'b1;
                    fin_bus = 1'b1;
                end else if (nack_evt) begin
                    fin      = 1'b1;
                    fin_nack = 1'b1;
                end else if (ok) begin
                    start_d = 1'b0;
                    cont_d  = (cnt_q != '0);
                    tx_d    = reg_q;
                    state_d = REG;
                end
            end

            // A zero-length request is a pointer-only write and ends here.
            REG: begin
                if (bus_err) begin
                    fin     = 1'b1;
                    fin_bus = 1'b1;
                end else if (nack_evt) begin
                    fin      = 1'b1;
                    fin_nack = 1'b1;
                end else if (ok) begin
                    if (cnt_q == '0) begin
                        fin = 1'b1;
                    end else begin
                        start_d = 1'b1;
                        cont_d  = 1'b1;
                        mode_d  = 1'b0;
                        tx_d    = {dev_q, 1'b1};
                        state_d = ADDR_R;
                    end
                end
            end

            ADDR_R: begin
                if (bus_err) begin
                    fin     = 1'b1;
                    fin_bus = 1'b1;
                end else if (nack_evt) begin
                    fin      = 1'b1;
                    fin_nack = 1'b1;
                end else if (ok) begin
                    start_d = 1'b0;
                    mode_d  = 1'b1;
                    cont_d  = (cnt_q > LEN_W'(1));
                    state_d = READ;
                end
            end

            // The master NACKs the final byte itself, so i2c_nack carries no error here.
            READ: begin
                if (bus_err) begin
                    fin     = 1'b1;
                    fin_bus = 1'b1;
                end else if (ok) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = i2c_data_rx;
                    rd_last_d  = (cnt_q == LEN_W'(1));
                    cnt_d      = cnt_q - LEN_W'(1);
                    cont_d     = (cnt_q > LEN_W'(2));
                    if (cnt_q == LEN_W'(1)) begin
                        fin = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            err_nack_d = fin_nack;
            err_bus_d  = fin_bus;
            start_d    = 1'b0;
            cont_d     = 1'b0;
            mode_d     = 1'b0;
        end
    end

    assign req_ready             = (state_q == IDLE);
    assign rd_valid              = rd_valid_q;
    assign rd_data               = rd_data_q;
    assign rd_last               = rd_last_q;
    assign done                  = done_q;
    assign err_nack              = err_nack_q;
    assign err_bus               = err_bus_q;
    assign i2c_mode              = mode_q;
    assign i2c_transfer_start    = start_q;
    assign i2c_transfer_continue = cont_q;
    assign i2c_data_tx           = tx_q;

endmodule

// File: doc/i2c_reg_reader.md
# i2c_reg_reader

Register-read sequencer that sits directly upstream of `i2c_master` and drives its byte-level handshake. It accepts one request at a time: 7-bit device address, 8-bit register pointer and byte count. It then runs the full transaction: address+W, register pointer, repeated start, address+R, then N read bytes with NACK on the last. Read bytes are returned as a valid/last stream, and a done/error pulse ends each request. It replaces hand-written per-device sequencing FSMs in top levels, such as the BQ24195 register poll.

## Interface
- `MAX_LEN`, default 4: maximum bytes per read request.
- `LEN_W`, default 3: width of `req_len`; must hold `MAX_LEN`.

Ports:
- `clk_in` in 1: the single clock; same clock as `i2c_master`.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: idle and able to accept a request.
- `req_dev_addr` in 7: target device address.
- `req_reg_addr` in 8: register pointer.
- `req_len` in LEN_W: bytes to read, 0..`MAX_LEN`. Values above `MAX_LEN` are clamped to `MAX_LEN`.
- `rd_valid` out 1: one-cycle strobe per byte read. There is no backpressure.
- `rd_data` out 8: the read byte.
- `rd_last` out 1: qualifies the final byte.
- `done` out 1: one-cycle pulse at the end of every accepted request, on success or failure.
- `err_nack` out 1: valid with `done`; set when a write-phase byte was NACKed.
- `err_bus` out 1: valid with `done`; set on `i2c_start_err` or `i2c_arbitration_err`.
- `i2c_mode` out 1: 0 = write byte, 1 = read byte.
- `i2c_transfer_start` out 1: issue (repeated) START before this byte.
- `i2c_transfer_continue` out 1: keep the bus after this byte. On a read byte, 1 = ACK and 0 = NACK+STOP.
- `i2c_data_tx` out 8: byte to transmit.
- `i2c_transfer_ready` in 1: master is idle with the bus free.
- `i2c_interrupt` in 1: one-cycle event from the master.
- `i2c_transaction_complete` in 1: valid with `i2c_interrupt`.
- `i2c_nack` in 1: valid with `i2c_interrupt`.
- `i2c_start_err` in 1: valid with `i2c_interrupt`.
- `i2c_arbitration_err` in 1: valid with `i2c_interrupt`.
- `i2c_data_rx` in 8: valid with `i2c_interrupt` in read mode.

## Operation
- All `i2c_*` controls are registered. They are held stable until the next qualifying interrupt.
- A qualifying interrupt ("ok") is `i2c_interrupt && i2c_transaction_complete` with no error flags set.
- FSM states: IDLE, WAIT_RDY, ADDR_W, REG, ADDR_R, READ.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the address, register pointer and length (`cnt` ← clamped `len`), then go to WAIT_RDY.
- **WAIT_RDY:** on `i2c_transfer_ready`, set start=1, continue=1, mode=0, tx={dev,0}, then go to ADDR_W.
- **ADDR_W, ok && !nack:** set start=0, continue=(cnt!=0), tx=reg, then go to REG.
- **REG, ok && !nack:**
  - If cnt==0, finish with success.
  - Otherwise set start=1, continue=1, mode=0, tx={dev,1}, then go to ADDR_R.
- **ADDR_R, ok && !nack:** set start=0, mode=1, continue=(cnt>1), then go to READ.
- **READ, ok:**
  - Emit `rd_data`=`i2c_data_rx`, with `rd_last`=(cnt==1). `i2c_nack` is ignored in READ.
  - Decrement cnt. continue ← (cnt after decrement > 1).
  - When cnt was 1, finish with success.
- **NACK:** in ADDR_W, REG or ADDR_R, an interrupt with `i2c_nack` finishes with `err_nack`=1.
- **Bus error:** in any active state, an interrupt with start_err or arbitration_err finishes with `err_bus`=1. Both flags may be set together.
- **Finish:** pulse `done` with the error flags, clear start/continue/mode to 0, and return to IDLE. STOP generation after an error is the master's responsibility.
- An interrupt with transaction_complete=0 and no error is ignored.

## Timing
- Reset values: `req_ready`=1; every other output is 0, including `i2c_data_tx`=0.
- Reset mid-transaction returns all outputs to these values immediately. No `done` is produced for the aborted request.
- Request acceptance cycle is `req_valid && req_ready`. `req_ready` is 0 from the next cycle until `done`.
- Control updates, `rd_valid`, `done` and the error flags appear exactly one cycle after the triggering `i2c_interrupt`.
- On a successful read, `rd_last` and `done` assert in the same cycle.
- `req_ready` reasserts in the same cycle as `done`. A new request may be accepted that cycle, so back-to-back requests are allowed.
- `done` is exactly one cycle wide. `err_*` are 0 whenever `done`=0.

## Test plan
1. **Single-byte read.** Request dev 0x6B, reg 0x08, len 1; the bench model returns 0x5A. Required:
   - `i2c_data_tx` sequence 0xD6, 0x08, 0xD7.
   - start 1, 0, 1; read byte has mode=1, continue=0.
   - One `rd_valid` with 0x5A and `rd_last`=1; `done`=1 with no error.
2. **Three-byte read.** len 3 with data 0x11, 0x22, 0x33. Required: three `rd_valid` strobes in order, `rd_last` only on 0x33, read-phase continue values 1, 1, 0, then `done`.
3. **Address NACK.** NACK on the first address byte. Required: `done` with `err_nack`=1, no `rd_valid`, start/continue cleared, `req_ready`=1 one cycle after the interrupt.
4. **Arbitration loss.** `i2c_arbitration_err` on the second read byte of len 3. Required: one `rd_valid` only (first byte, `rd_last`=0), then `done` with `err_bus`=1.
5. **Pointer-only write and back-to-back.** len 0 gives tx 0xD6 then 0x08 with continue=0, no ADDR_R, `done` with no error. A second request held on `req_valid` is accepted in the `done` cycle.
6. **Reset mid-read.** Assert `reset_n` low during READ. Required: all outputs go to reset values asynchronously with no `done`. A following len 1 request completes normally.
